// File: rtl/pico_cyc10_qys_key_pio_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// Transfer rules: a write is taken on every clk edge where chipselect && !write_n, with no wait states.
// readdata is valid in the same cycle as address, regardless of chipselect, with no read latency.
interface pico_cyc10_qys_key_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pico_cyc10_qys_key_pio.sv
// Push-button/switch input PIO: synchronise, optional tick-based debounce, edge detect,
// sticky edge capture with W1C clear, and a maskable level interrupt.
module pico_cyc10_qys_key_pio #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IN_RESET        = '0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    pico_cyc10_qys_key_pio_if.slave        bus,
    input  logic [WIDTH-1:0]               in_port,
    output logic                           irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap_clr;
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = bus.chipselect && !bus.write_n;
    // Bits of writedata above WIDTH-1 are intentionally ignored.
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET;
            sync2 <= IN_RESET;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    debounced <= IN_RESET;
                end else begin
                    debounced <= sync2;
                end
            end
        end else begin : g_debounce
            localparam int                CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] prescale;
            logic             tick;
            logic [WIDTH-1:0] hist0;
            logic [WIDTH-1:0] hist1;
            logic [WIDTH-1:0] agree;

            assign tick  = (prescale == CNT_MAX);
            // A bit may only move once three consecutive tick samples agree.
            assign agree = ~(sync2 ^ hist0) & ~(hist0 ^ hist1);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prescale <= '0;
                end else if (tick) begin
                    prescale <= '0;
                end else begin
                    prescale <= prescale + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hist0     <= IN_RESET;
                    hist1     <= IN_RESET;
                    debounced <= IN_RESET;
                end else if (tick) begin
                    hist0     <= sync2;
                    hist1     <= hist0;
                    debounced <= (debounced & ~agree) | (sync2 & agree);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev <= IN_RESET;
        end else begin
            deb_prev <= debounced;
        end
    end

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = debounced & ~deb_prev;
            1:       edge_det = ~debounced & deb_prev;
            default: edge_det = debounced ^ deb_prev;
        endcase
    end

    always_comb begin
        edgecap_clr = '0;
        if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            edgecap_clr = bus.writedata[WIDTH-1:0];
        end
    end

    // A fresh edge in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~edgecap_clr) | edge_det;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && (bus.address == ADDR_IRQMASK)) begin
            irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    assign irq = |(edgecap & irqmask);

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata[WIDTH-1:0] = debounced;
            ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecap;
            default:      bus.readdata = '0;
        endcase
    end

endmodule
